// File: rtl/compare_accumulator.sv
// Word-level magnitude compare: folds MSB-first per-bit compare vectors into one result per word.
// Optional one-hot checking of incoming compare vectors is enabled with `define CMP_ACC_ERR_EN.
module compare_accumulator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] c,
  input  logic       valid,
  input  logic       start,
  output logic [2:0] res,
  output logic       done,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [2:0]       dec, dec_d;
  logic [2:0]       res_d;
  logic [2:0]       c_res;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             flag, flag_d;
  logic             done_d, busy_d;
  logic             load;
  logic             bad_c;

  assign load = valid & start;

`ifdef CMP_ACC_ERR_EN
  assign bad_c = !((c == 3'b100) || (c == 3'b010) || (c == 3'b001));
`else
  assign bad_c = 1'b0;
`endif

  // Collapse a possibly malformed vector: greater wins over less, less over equal.
  always_comb begin
    c_res = 3'b010;
    if (c[2]) begin
      c_res = 3'b100;
    end else if (c[0]) begin
      c_res = 3'b001;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    dec_d   = dec;
    cnt_d   = cnt;
    flag_d  = flag;
    res_d   = res;
    done_d  = 1'b0;
    busy_d  = 1'b0;

    if (load) begin
      dec_d   = c_res;
      cnt_d   = CNT_W'(1);
      flag_d  = bad_c;
      state_d = (WIDTH == 1) ? DONE : ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (valid) begin
            // Decision is sticky once a and b differ.
            dec_d  = (dec == 3'b010) ? c_res : dec;
            cnt_d  = cnt + CNT_W'(1);
            flag_d = flag | bad_c;
            if (cnt_d == CNT_W'(WIDTH)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    done_d = (state_d == DONE);
    busy_d = (state_d == ACCUM);
    if (done_d) begin
      res_d = flag_d ? 3'b000 : dec_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dec   <= 3'b000;
      cnt   <= '0;
      flag  <= 1'b0;
      res   <= 3'b000;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      dec   <= dec_d;
      cnt   <= cnt_d;
      flag  <= flag_d;
      res   <= res_d;
      done  <= done_d;
      busy  <= busy_d;
    end
  end

`ifdef CMP_ACC_ERR_EN
  logic err_d;

  // Error status is latched with res and held until the next report.
  always_comb begin
    err_d = err;
    if (done_d) begin
      err_d = flag_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_compare_accumulator.sv
// Directed-vector bench for compare_accumulator with a word-level reference model.
module tb_compare_accumulator;

  localparam int unsigned WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] c;
  logic       valid;
  logic       start;
  logic [2:0] res;
  logic       done;
  logic       busy;
  logic       err;

  compare_accumulator #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .c    (c),
    .valid(valid),
    .start(start),
    .res  (res),
    .done (done),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int n_lit = 0;
  int n_lit_mis = 0;
  int cyc = 0;

  // Reference model: collect the raw vectors of the current word, judge the word once complete.
  logic [2:0] m_bits[$];
  bit         m_in;
  logic       e_done, e_busy, e_err;
  logic [2:0] e_res;

  function automatic logic [3:0] judge_word();
    logic [2:0] r;
    bit         bad;
    bit         found;
    r = 3'b010;
    bad = 1'b0;
    found = 1'b0;
    for (int i = 0; i < m_bits.size(); i++) begin
      if (m_bits[i] != 3'b100 && m_bits[i] != 3'b010 && m_bits[i] != 3'b001) bad = 1'b1;
      if (!found) begin
        if (m_bits[i][2]) begin
          r = 3'b100;
          found = 1'b1;
        end else if (m_bits[i][0]) begin
          r = 3'b001;
          found = 1'b1;
        end
      end
    end
`ifdef CMP_ACC_ERR_EN
    if (bad) r = 3'b000;
    return {bad, r};
`else
    return {1'b0, r};
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bits.delete();
      m_in   = 1'b0;
      e_done = 1'b0;
      e_busy = 1'b0;
      e_err  = 1'b0;
      e_res  = 3'b000;
    end else begin
      logic [3:0] j;
      e_done = 1'b0;
      if (valid && start) begin
        m_bits.delete();
        m_bits.push_back(c);
        m_in = 1'b1;
      end else if (valid && m_in) begin
        m_bits.push_back(c);
      end
      if (m_in && m_bits.size() == WIDTH) begin
        j      = judge_word();
        e_done = 1'b1;
        e_err  = j[3];
        e_res  = j[2:0];
        m_in   = 1'b0;
        m_bits.delete();
      end
      e_busy = m_in;
    end
  end

  // Every cycle: DUT outputs must match the model.
  always @(negedge clk) begin
    cyc++;
    n_vec++;
    if ({done, busy, err, res} !== {e_done, e_busy, e_err, e_res}) begin
      n_mis++;
      $display("FAIL cycle %0d model: {done,busy,err,res} got %b_%b_%b_%b required %b_%b_%b_%b",
               cyc, done, busy, err, res, e_done, e_busy, e_err, e_res);
    end
  end

  task automatic drive(input logic v, input logic s, input logic [2:0] cv);
    @(negedge clk);
    valid = v;
    start = s;
    c     = cv;
  endtask

  task automatic word4(input logic [2:0] b0, input logic [2:0] b1,
                       input logic [2:0] b2, input logic [2:0] b3);
    drive(1'b1, 1'b1, b0);
    drive(1'b1, 1'b0, b1);
    drive(1'b1, 1'b0, b2);
    drive(1'b1, 1'b0, b3);
  endtask

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_lit++;
    if (got !== exp) begin
      n_lit_mis++;
      $display("FAIL %s: {done,busy,err,res} got %b required %b", name, got, exp);
    end
  endtask

  // Check on the cycle after the edge that accepts the currently driven bit.
  task automatic lit(input string name, input logic [5:0] exp);
    @(posedge clk);
    #1;
    chk(name, {done, busy, err, res}, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; start = 1'b0; c = 3'b000;
    #1;
    chk("reset_state", {done, busy, err, res}, 6'b000_000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'b000);

    // a>b decided on bit 1, later less bits ignored
    word4(3'b010, 3'b100, 3'b001, 3'b001);
    lit("gt_word", 6'b100_100);
    drive(1'b0, 1'b0, 3'b000);

    // valid without start in IDLE is ignored
    drive(1'b1, 1'b0, 3'b001);
    drive(1'b0, 1'b0, 3'b000);
    lit("idle_ignore", 6'b000_100);

    word4(3'b010, 3'b010, 3'b010, 3'b010);
    lit("all_equal", 6'b100_010);
    drive(1'b0, 1'b0, 3'b000);
    word4(3'b010, 3'b010, 3'b010, 3'b001);
    lit("lsb_less", 6'b100_001);

    // back-to-back: next start presented while done is high
    word4(3'b100, 3'b010, 3'b010, 3'b010);
    lit("b2b_first", 6'b100_100);
    word4(3'b001, 3'b100, 3'b100, 3'b100);
    lit("b2b_second", 6'b100_001);
    drive(1'b0, 1'b0, 3'b000);

    // gaps mid-word hold state
    drive(1'b1, 1'b1, 3'b010);
    drive(1'b0, 1'b0, 3'b000);
    drive(1'b0, 1'b0, 3'b000);
    lit("gap_busy", 6'b010_001);
    drive(1'b1, 1'b0, 3'b010);
    drive(1'b0, 1'b0, 3'b000);
    drive(1'b1, 1'b0, 3'b100);
    drive(1'b1, 1'b0, 3'b001);
    lit("gap_word", 6'b100_100);
    drive(1'b0, 1'b0, 3'b000);

    // restart after two bits: aborted word never reported
    drive(1'b1, 1'b1, 3'b100);
    drive(1'b1, 1'b0, 3'b010);
    word4(3'b001, 3'b010, 3'b010, 3'b010);
    lit("restart", 6'b100_001);

    // valid without start during done is ignored
    drive(1'b1, 1'b0, 3'b100);
    lit("done_ignore", 6'b000_001);
    drive(1'b0, 1'b0, 3'b000);

    // malformed vector in bit 2
    word4(3'b010, 3'b110, 3'b010, 3'b010);
`ifdef CMP_ACC_ERR_EN
    lit("bad_onehot", 6'b101_000);
`else
    lit("bad_onehot", 6'b100_100);
`endif
    drive(1'b0, 1'b0, 3'b000);
    word4(3'b010, 3'b001, 3'b100, 3'b100);
    lit("clean_after_bad", 6'b100_001);
    drive(1'b0, 1'b0, 3'b000);
`ifndef CMP_ACC_ERR_EN
    word4(3'b000, 3'b011, 3'b100, 3'b100);
    lit("zero_then_011", 6'b100_001);
    drive(1'b0, 1'b0, 3'b000);
`endif

    // asynchronous reset after three accepted bits
    drive(1'b1, 1'b1, 3'b010);
    drive(1'b1, 1'b0, 3'b010);
    drive(1'b1, 1'b0, 3'b100);
    lit("pre_reset_busy", 6'b010_001);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset", {done, busy, err, res}, 6'b000_000);
    drive(1'b0, 1'b0, 3'b000);
    rst = 1'b0;
    drive(1'b1, 1'b0, 3'b100);
    lit("post_reset_idle", 6'b000_000);
    word4(3'b001, 3'b001, 3'b001, 3'b001);
    lit("post_reset_word", 6'b100_001);
    drive(1'b0, 1'b0, 3'b000);
    repeat (3) @(negedge clk);

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec + n_lit, n_mis + n_lit_mis);
    $finish;
  end

endmodule

// File: doc/compare_accumulator.md
COMPARE_ACCUMULATOR -- requirements
Module: compare_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the number of bit-compare results per operand word (legal range 1..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port c, input, 3, the per-bit compare vector from the upstream 1-bit comparator: c[2] means a>b, c[1] means a==b, c[0] means a<b.
REQ-005 SHALL have port valid, input, 1: c is presented this cycle.
REQ-006 SHALL have port start, input, 1: the current c is the MSB (first bit) of a new word; it is qualified by valid.
REQ-007 SHALL have port res, output, 3, the word-level compare result with the same encoding as c.
REQ-008 SHALL have port done, output, 1: a single-cycle pulse indicating res was updated.
REQ-009 SHALL have port busy, output, 1: high while a word is partially accumulated.
REQ-010 SHALL have port err, output, 1: a non-one-hot c was seen in the reported word.

Function
REQ-011 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-012 SHALL, in IDLE, ignore valid without start.
REQ-013 SHALL, in IDLE on valid&start, load the decision from c, set the bit count to 1 and go to ACCUM (or to DONE if WIDTH==1).
REQ-014 SHALL process bits MSB-first; the decision is sticky: once it is a>b or a<b, later bits do not change it, and while it is a==b each accepted bit overwrites it.
REQ-015 SHALL, in ACCUM on valid without start, accept the bit and increment the count; when the count reaches WIDTH, go to DONE.
REQ-016 SHALL, in ACCUM on valid&start, abort the current word with no done pulse and restart with this bit as the new MSB (count=1).
REQ-017 SHALL, in ACCUM without valid, hold all state; there is no timeout.
REQ-018 SHALL, in DONE, drive done=1 for exactly one cycle with res=decision; res then holds until the next done.
REQ-019 SHALL, in DONE on valid&start, begin the next word (back-to-back, zero bubble); otherwise go to IDLE; valid without start in DONE is ignored.
REQ-020 SHALL assert done on the cycle after the WIDTH-th bit is accepted (latency 1).
REQ-021 SHALL drive busy=1 in ACCUM only.
REQ-022 SHALL size the counter as $clog2(WIDTH+1) bits with no wrap-around; the count never exceeds WIDTH.

Reset
REQ-023 SHALL, on rst asserted at any time including mid-word, immediately force state=IDLE, res=3'b000, done=0, busy=0, err=0 and count=0.
REQ-024 SHALL discard any partially accumulated word on reset and never report it.

Configuration
REQ-025 SHALL, with macro CMP_ACC_ERR_EN defined, check every accepted c for one-hot; a violation sets a sticky internal flag cleared on each start; at done, err=flag and res=3'b000 if flag is set; err holds with res.
REQ-026 SHALL, with CMP_ACC_ERR_EN undefined, keep the err port present and tied 0 with no checking, and resolve non-one-hot c by priority c[2] > c[0] > c[1] (3'b000 treated as equal).

Verification
REQ-027 SHALL cover: WIDTH=4, c sequence 010,100,001,001 (start on first) -> done one cycle after 4th bit, res=100, err=0.
REQ-028 SHALL cover: WIDTH=4, all four c=010 -> res=010; then 010,010,010,001 -> res=001.
REQ-029 SHALL cover: two words back-to-back, start on the cycle done is high -> second done exactly 4 cycles after the first, no lost bit.
REQ-030 SHALL cover: start reasserted after 2 bits of word (100,010 then start 001,010,010,010) -> single done, res=001.
REQ-031 SHALL cover: rst pulsed after 3 accepted bits -> outputs zero asynchronously; a following full word 001x4 -> res=001.
REQ-032 SHALL cover: with CMP_ACC_ERR_EN defined, c=110 in bit 2 -> done with res=000, err=1; next clean word -> err=0.
